// File: rtl/aes_key_mix_round_if.sv
// -----------------------------------------------------------------------------
// aes_key_mix_round_if
// Bundles the request/response signals of aes_key_mix_round.
//   start     : one-cycle pulse, latch key and begin expansion
//   key       : 128-bit cipher key, key[127:96] = w[0]
//   key_busy  : expansion in progress
//   key_ready : all 11 round keys valid
//   op_valid  : round-operation request
//   op_state  : 128-bit state, byte 0 = [127:120], column-major
//   op_round  : round-key index 0..10
//   op_mix    : 1 = apply MixColumns before AddRoundKey
//   out_valid : one-cycle result pulse
//   out_state : result, held while out_valid = 0
//   op_err    : pulses with out_valid for an invalid request
//   rk_idx    : round-key read index
//   rk_out    : round key rk_idx (combinational)
// Modports: master drives requests (bench/host), slave is the block itself.
// -----------------------------------------------------------------------------
interface aes_key_mix_round_if;
  logic         start;
  logic [127:0] key;
  logic         key_busy;
  logic         key_ready;
  logic         op_valid;
  logic [127:0] op_state;
  logic [3:0]   op_round;
  logic         op_mix;
  logic         out_valid;
  logic [127:0] out_state;
  logic         op_err;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  modport master (
    output start, key, op_valid, op_state, op_round, op_mix, rk_idx,
    input  key_busy, key_ready, out_valid, out_state, op_err, rk_out
  );

  modport slave (
    input  start, key, op_valid, op_state, op_round, op_mix, rk_idx,
    output key_busy, key_ready, out_valid, out_state, op_err, rk_out
  );
endinterface

// File: rtl/aes_key_mix_round.sv
// -----------------------------------------------------------------------------
// aes_key_mix_round
// AES-128 key expansion (one round key per cycle) plus a single-cycle
// (MixColumns?) + AddRoundKey round operation against the stored keys.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : aes_key_mix_round_if.slave (see interface header for signals)
// Parameters:
//   NK   : key length in 32-bit words, only 4 supported
//   NR   : number of rounds, only 10 supported
// Configuration macro:
//   AES_RK_READ_PORT_EN : defined -> rk_out returns round key rk_idx while
//                         key_ready and rk_idx <= NR, else 0;
//                         undefined -> rk_out tied to 0, rk_idx ignored.
// -----------------------------------------------------------------------------

// GF(2^8) S-box: multiplicative inverse (x^254) followed by the AES affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = '0;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = xtime(xx);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;

  assign inv = gf_inv(a);
  assign s   = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
endmodule

module aes_key_mix_round #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                clk,
  input  logic                rst,
  aes_key_mix_round_if.slave  bus
);
  localparam int KEY_BITS = 32 * NK;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_READY
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;      // index of the round key being built
  logic [KEY_BITS-1:0] rk [0:NR];

  logic                key_ready;
  logic                key_busy;

  assign key_ready = (state_q == ST_READY);
  assign key_busy  = (state_q == ST_EXPAND);

  // ---------------------------------------------------------------------------
  // Expansion control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.start) begin
      // A new start always restarts, even mid-expansion or when ready.
      state_d = ST_EXPAND;
      cnt_d   = 4'd1;
    end else if (state_q == ST_EXPAND) begin
      if (cnt_q == 4'(NR)) state_d = ST_READY;
      else                 cnt_d   = cnt_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Key schedule datapath: derive rk[cnt] from rk[cnt-1] with four S-boxes.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  logic [3:0]   prev_idx;
  logic [127:0] prev_rk;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [31:0]  t_w;
  logic [31:0]  n0, n1, n2, n3;

  assign prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
  assign prev_rk  = rk[prev_idx];
  assign rot_w    = {prev_rk[23:0], prev_rk[31:24]};

  aes_sbox u_sbox0 (.a(rot_w[31:24]), .s(sub_w[31:24]));
  aes_sbox u_sbox1 (.a(rot_w[23:16]), .s(sub_w[23:16]));
  aes_sbox u_sbox2 (.a(rot_w[15:8]),  .s(sub_w[15:8]));
  aes_sbox u_sbox3 (.a(rot_w[7:0]),   .s(sub_w[7:0]));

  assign t_w = sub_w ^ {rcon(cnt_q), 24'h0};
  assign n0  = prev_rk[127:96] ^ t_w;
  assign n1  = prev_rk[95:64]  ^ n0;
  assign n2  = prev_rk[63:32]  ^ n1;
  assign n3  = prev_rk[31:0]   ^ n2;

  always_ff @(posedge clk) begin
    // NOTE: rk is a small register file, not a RAM macro, so it is reset:
    // stale keys must never be observable after rst.
    if (rst) begin
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else if (bus.start) begin
      rk[0] <= bus.key;
    end else if (state_q == ST_EXPAND) begin
      rk[cnt_q] <= {n0, n1, n2, n3};
    end
  end

  // ---------------------------------------------------------------------------
  // Round operation: (op_mix ? MixColumns(state) : state) ^ rk[op_round]
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] r0, r1, r2, r3;
    {s0, s1, s2, s3} = c;
    r0 = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
    r1 = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
    r2 = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
    r3 = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);
    return {r0, r1, r2, r3};
  endfunction

  logic [127:0] mixed;
  logic [127:0] op_in;
  logic         op_bad;
  logic         out_valid_q;
  logic         op_err_q;
  logic [127:0] out_state_q;

  assign mixed  = {mix_col(bus.op_state[127:96]), mix_col(bus.op_state[95:64]),
                   mix_col(bus.op_state[63:32]),  mix_col(bus.op_state[31:0])};
  assign op_in  = bus.op_mix ? mixed : bus.op_state;
  assign op_bad = !key_ready || (bus.op_round > 4'(NR));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      op_err_q    <= 1'b0;
      out_state_q <= '0;
    end else if (bus.op_valid) begin
      out_valid_q <= 1'b1;
      op_err_q    <= op_bad;
      out_state_q <= op_bad ? '0 : (op_in ^ rk[bus.op_round]);
    end else begin
      // out_state deliberately holds its last value between results.
      out_valid_q <= 1'b0;
      op_err_q    <= 1'b0;
    end
  end

  assign bus.key_busy  = key_busy;
  assign bus.key_ready = key_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.op_err    = op_err_q;
  assign bus.out_state = out_state_q;

  // ---------------------------------------------------------------------------
  // Optional round-key read port
  // ---------------------------------------------------------------------------
`ifdef AES_RK_READ_PORT_EN
  assign bus.rk_out = (key_ready && (bus.rk_idx <= 4'(NR))) ? rk[bus.rk_idx] : '0;
`else
  logic [3:0] unused_rk_idx;
  assign unused_rk_idx = bus.rk_idx;
  assign bus.rk_out    = '0;
`endif
endmodule

// File: tb/tb_aes_key_mix_round.sv
// -----------------------------------------------------------------------------
// tb_aes_key_mix_round
// Self-checking bench for aes_key_mix_round. A behavioural model (word-level
// FIPS-197 key expansion, matrix MixColumns, brute-force S-box) predicts
// every output; a compare process checks them each cycle, and directed
// vectors check FIPS-197 / known-answer literals.
// -----------------------------------------------------------------------------
module tb_aes_key_mix_round;
  logic clk = 1'b0;
  logic rst;

  aes_key_mix_round_if bus ();

  aes_key_mix_round #(.NK(4), .NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [7:0] sb [0:255];
  logic [7:0] rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Carry-less product then reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (15'h11b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] m_sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] r;
    inv = 8'h00;
    c   = 8'h63;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (m_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      r[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
           ^ inv[(i + 7) % 8] ^ c[i];
    return r;
  endfunction

  function automatic logic [10:0][127:0] m_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [10:0][127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rcon_tab[i / 4 - 1], 24'h0};
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) res[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    return res;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] s);
    int         m [0:3][0:3] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    logic [7:0] acc;
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ m_gmul(8'(m[r][k]), s[127 - 8 * (4 * c + k) -: 8]);
        res[127 - 8 * (4 * c + r) -: 8] = acc;
      end
    return res;
  endfunction

  logic [10:0][127:0] m_rk;
  logic               m_busy  = 1'b0;
  logic               m_ready = 1'b0;
  int                 m_cnt   = 0;
  logic               e_valid = 1'b0;
  logic               e_err   = 1'b0;
  logic [127:0]       e_state = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_cnt   <= 0;
      e_valid <= 1'b0;
      e_err   <= 1'b0;
      e_state <= '0;
    end else begin
      e_valid <= bus.op_valid;
      if (bus.op_valid) begin
        if (!m_ready || bus.op_round > 10) begin
          e_err   <= 1'b1;
          e_state <= '0;
        end else begin
          e_err   <= 1'b0;
          e_state <= (bus.op_mix ? m_mix(bus.op_state) : bus.op_state) ^ m_rk[bus.op_round];
        end
      end else begin
        e_err <= 1'b0;
      end
      if (bus.start) begin
        m_rk    <= m_expand(bus.key);
        m_busy  <= 1'b1;
        m_ready <= 1'b0;
        m_cnt   <= 0;
      end else if (m_busy) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == 9) begin
          m_busy  <= 1'b0;
          m_ready <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare, away from the active edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("key_busy",  128'(bus.key_busy),  128'(m_busy));
      check("key_ready", 128'(bus.key_ready), 128'(m_ready));
      check("out_valid", 128'(bus.out_valid), 128'(e_valid));
      check("op_err",    128'(bus.op_err),    128'(e_err));
      check("out_state", bus.out_state, e_state);
`ifdef AES_RK_READ_PORT_EN
      check("rk_out", bus.rk_out, (m_ready && bus.rk_idx <= 10) ? m_rk[bus.rk_idx] : 128'h0);
`else
      check("rk_out", bus.rk_out, 128'h0);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_A   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_A  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK1_Z   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] RK10_Z  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_key(input logic [127:0] k);
    bus.key   = k;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.key_ready && n < 40) begin
      tick();
      n++;
    end
    check(name, 128'(n), 128'd10);
  endtask

  task automatic do_op(input logic [127:0] s, input logic [3:0] r, input logic m);
    bus.op_valid = 1'b1;
    bus.op_state = s;
    bus.op_round = r;
    bus.op_mix   = m;
    tick();
    bus.op_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sb[i] = m_sbox_calc(8'(i));
    check("model_sbox_00", 128'(sb[8'h00]), 128'h63);
    check("model_sbox_53", 128'(sb[8'h53]), 128'hed);

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.key      = '0;
    bus.op_valid = 1'b0;
    bus.op_state = '0;
    bus.op_round = '0;
    bus.op_mix   = 1'b0;
    bus.rk_idx   = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_busy",  128'(bus.key_busy),  128'h0);
    check("reset_ready", 128'(bus.key_ready), 128'h0);
    check("reset_state", bus.out_state,       128'h0);

    // Request before any key is ready -> error pulse, zero result.
    do_op(128'h0123456789abcdef0123456789abcdef, 4'd0, 1'b0);
    check("early_valid", 128'(bus.out_valid), 128'h1);
    check("early_err",   128'(bus.op_err),    128'h1);
    check("early_state", bus.out_state,       128'h0);

    // FIPS-197 key, 10-cycle expansion.
    start_key(KEY_A);
    check("start_busy", 128'(bus.key_busy), 128'h1);
    check("model_rk1_a",  m_rk[1],  RK1_A);
    check("model_rk10_a", m_rk[10], RK10_A);
    wait_ready("latency_a");

    do_op(128'h3243f6a8885a308d313198a2e0370734, 4'd0, 1'b0);
    check("ark_round0", bus.out_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

    // Back-to-back requests: rk1, rk10, then out-of-range round 11.
    bus.op_valid = 1'b1;
    bus.op_state = '0;
    bus.op_mix   = 1'b0;
    bus.op_round = 4'd1;
    tick();
    check("b2b_rk1", bus.out_state, RK1_A);
    bus.op_round = 4'd10;
    tick();
    check("b2b_rk10", bus.out_state, RK10_A);
    bus.op_round = 4'd11;
    tick();
    check("round11_err",   128'(bus.op_err), 128'h1);
    check("round11_state", bus.out_state,    128'h0);
    bus.op_round = 4'd2;
    tick();
    bus.op_valid = 1'b0;
    tick();
    tick();
    check("hold_valid", 128'(bus.out_valid), 128'h0);

    // Sweep the read port including out-of-range indices.
    for (int i = 0; i < 16; i++) begin
      bus.rk_idx = 4'(i);
      tick();
    end

    // Start while ready: ready drops on the sampling edge, busy rises.
    start_key('0);
    check("restart_ready", 128'(bus.key_ready), 128'h0);
    check("restart_busy",  128'(bus.key_busy),  128'h1);
    wait_ready("latency_z");
    do_op(128'hdb135345f20a225c01010101c6c6c6c6, 4'd0, 1'b1);
    check("mix_round0", bus.out_state, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);
    do_op('0, 4'd1, 1'b0);
    check("zero_rk1", bus.out_state, RK1_Z);
    do_op('0, 4'd10, 1'b0);
    check("zero_rk10", bus.out_state, RK10_Z);
    bus.rk_idx = 4'd10;

    // Restart mid-expansion: result must reflect only the new key.
    start_key(KEY_A);
    tick();
    tick();
    start_key('0);
    wait_ready("latency_mid_restart");
    do_op('0, 4'd10, 1'b0);
    check("mid_restart_rk10", bus.out_state, RK10_Z);

    // rst 5 cycles after start, together with start and op_valid.
    start_key(KEY_A);
    for (int i = 0; i < 4; i++) tick();
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.op_valid = 1'b1;
    tick();
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.op_valid = 1'b0;
    check("rst_busy",  128'(bus.key_busy),  128'h0);
    check("rst_ready", 128'(bus.key_ready), 128'h0);
    check("rst_valid", 128'(bus.out_valid), 128'h0);
    start_key(KEY_A);
    wait_ready("latency_after_rst");
    do_op('0, 4'd1, 1'b0);
    check("after_rst_rk1", bus.out_state, RK1_A);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aes_key_mix_round.md
AES_KEY_MIX_ROUND -- requirements
Module: aes_key_mix_round

Interface
REQ-001 Parameter NK, default 4, key length in 32-bit words; only 4 (AES-128) SHALL be supported.
REQ-002 Parameter NR, default 10, number of rounds; only 10 SHALL be supported.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse; latch key and begin key expansion.
REQ-007 key  input  128  cipher key; key[127:96] = w[0].
REQ-008 key_busy  output  1  expansion in progress.
REQ-009 key_ready  output  1  all 11 round keys valid.
REQ-010 op_valid  input  1  request a round operation.
REQ-011 op_state  input  128  state; byte 0 = [127:120], column-major (FIPS-197 order).
REQ-012 op_round  input  4  round-key index 0..10.
REQ-013 op_mix  input  1  1 = apply MixColumns before AddRoundKey.
REQ-014 out_valid  output  1  result valid, one-cycle pulse.
REQ-015 out_state  output  128  result.
REQ-016 op_err  output  1  pulses with out_valid when request was invalid.
REQ-017 rk_idx  input  4  round-key read index.
REQ-018 rk_out  output  128  round key rk_idx, combinational read.

Function
REQ-019 Key expansion SHALL follow FIPS-197 AES-128: w[i] = w[i-4] ^ (i%4==0 ? SubWord(RotWord(w[i-1])) ^ Rcon[i/4] : w[i-1]); Rcon = 01,02,04,08,10,20,40,80,1b,36.
REQ-020 On the edge sampling start=1, rk[0] SHALL be loaded with key, key_busy=1, key_ready=0.
REQ-021 One round key SHALL be produced per cycle; rk[i] SHALL be valid i cycles after start was sampled; key_ready SHALL rise and key_busy fall exactly 10 cycles after start was sampled.
REQ-022 start while key_busy or key_ready SHALL restart expansion from the new key; key_ready SHALL drop on the sampling edge.
REQ-023 S-box SHALL be a 256-entry table or GF(2^8) inversion plus affine; four S-box instances SHALL be used per cycle.
REQ-024 MixColumns SHALL use per column [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8), polynomial 0x11b.
REQ-025 Round result SHALL be (op_mix ? MixColumns(op_state) : op_state) ^ rk[op_round].
REQ-026 op_valid sampled high SHALL produce out_valid exactly one cycle later; back-to-back requests SHALL be accepted every cycle.
REQ-027 If key_ready=0 or op_round>10 at request, out_valid SHALL still pulse with op_err=1 and out_state=0.
REQ-028 out_state SHALL hold its last value when out_valid=0.
REQ-029 rk_out SHALL be 0 for rk_idx>10 or when key_ready=0.

Reset
REQ-030 rst SHALL clear key_busy, key_ready, out_valid, op_err, out_state, round counter and all round-key registers to 0.
REQ-031 rst SHALL take priority over start and op_valid in the same cycle; rst mid-expansion SHALL abort it.

Configuration
REQ-032 Macro AES_RK_READ_PORT_EN: defined -> rk_idx/rk_out behave per REQ-018/029; undefined -> rk_out tied to 0, rk_idx ignored, ports retained.

Verification
REQ-033 key=000102030405060708090a0b0c0d0e0f... replaced: key=2b7e151628aed2a6abf7158809cf4f3c, start -> after 10 cycles key_ready=1; rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 key=0, start -> rk[1]=62636363626363636263636362636363, rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-035 key=0 ready, op_state=db135345f20a225c01010101c6c6c6c6, op_round=0, op_mix=1 -> next cycle out_state=8e4da1bc9fdc589d01010101c6c6c6c6.
REQ-036 key=2b7e...4f3c ready, op_state=3243f6a8885a308d313198a2e0370734, op_round=0, op_mix=0 -> out_state=193de3bea0f4e22b9ac68d2ae9f84808.
REQ-037 op_valid before key_ready, and op_round=11 after ready -> out_valid=1, op_err=1, out_state=0.
REQ-038 rst asserted 5 cycles after start -> key_busy=0, key_ready=0 next cycle; new start completes normally after 10 cycles.
